// File: rtl/alu_if.sv
// Operand/result bundle for the registered ALU; the sequencer drives the master side.
// Zero/Overflow exist only when ALU_STATUS_FLAGS_EN is defined.
interface alu_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             in_valid;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             out_valid;
`ifdef ALU_STATUS_FLAGS_EN
  logic             Zero;
  logic             Overflow;
`endif

`ifdef ALU_STATUS_FLAGS_EN
  modport master (output A, B, ALU_Sel, in_valid,
                  input  ALU_Out, CarryOut, out_valid, Zero, Overflow);
  modport slave  (input  A, B, ALU_Sel, in_valid,
                  output ALU_Out, CarryOut, out_valid, Zero, Overflow);
`else
  modport master (output A, B, ALU_Sel, in_valid,
                  input  ALU_Out, CarryOut, out_valid);
  modport slave  (input  A, B, ALU_Sel, in_valid,
                  output ALU_Out, CarryOut, out_valid);
`endif
endinterface

// File: rtl/alu.sv
// Registered 16-operation ALU with one-cycle latency and hold-on-idle outputs.
// Optional Zero/Overflow status flags are built when ALU_STATUS_FLAGS_EN is defined.
module alu #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  alu_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
  } op_e;

  localparam int MSB = WIDTH - 1;

  op_e              op;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   diff_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;

  logic [WIDTH-1:0] alu_out_q;
  logic             carry_q;
  logic             valid_q;

  assign op     = op_e'(bus.ALU_Sel);
  assign sum_d  = {1'b0, bus.A} + {1'b0, bus.B};
  // Top bit of the widened difference is the borrow.
  assign diff_d = {1'b0, bus.A} - {1'b0, bus.B};
  assign prod_d = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    res_d   = '0;
    carry_d = 1'b0;
    case (op)
      OP_ADD:  {carry_d, res_d} = sum_d;
      OP_SUB:  {carry_d, res_d} = diff_d;
      OP_MUL: begin
        res_d   = prod_d[WIDTH-1:0];
        carry_d = |prod_d[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (bus.B == '0) begin
          res_d   = '1;
          carry_d = 1'b1;
        end else begin
          res_d = bus.A / bus.B;
        end
      end
      OP_SHL: begin
        res_d   = {bus.A[MSB-1:0], 1'b0};
        carry_d = bus.A[MSB];
      end
      OP_SHR: begin
        res_d   = {1'b0, bus.A[MSB:1]};
        carry_d = bus.A[0];
      end
      OP_ROL:  res_d = {bus.A[MSB-1:0], bus.A[MSB]};
      OP_ROR:  res_d = {bus.A[0], bus.A[MSB:1]};
      OP_AND:  res_d = bus.A & bus.B;
      OP_OR:   res_d = bus.A | bus.B;
      OP_XOR:  res_d = bus.A ^ bus.B;
      OP_NOR:  res_d = ~(bus.A | bus.B);
      OP_NAND: res_d = ~(bus.A & bus.B);
      OP_XNOR: res_d = ~(bus.A ^ bus.B);
      OP_GT:   res_d = {{(WIDTH-1){1'b0}}, bus.A > bus.B};
      OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, bus.A == bus.B};
      default: ;
    endcase
  end

  // Result registers update only on valid cycles; out_valid tracks in_valid every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        alu_out_q <= res_d;
        carry_q   <= carry_d;
      end
    end
  end

  assign bus.ALU_Out   = alu_out_q;
  assign bus.CarryOut  = carry_q;
  assign bus.out_valid = valid_q;

`ifdef ALU_STATUS_FLAGS_EN
  logic ovf_d;
  logic zero_q;
  logic ovf_q;

  // Signed overflow: ADD with like-signed operands, SUB with unlike-signed, result sign flips from A.
  always_comb begin
    ovf_d = 1'b0;
    if (op == OP_ADD)
      ovf_d = (bus.A[MSB] == bus.B[MSB]) && (sum_d[MSB] != bus.A[MSB]);
    else if (op == OP_SUB)
      ovf_d = (bus.A[MSB] != bus.B[MSB]) && (diff_d[MSB] != bus.A[MSB]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.in_valid) begin
      zero_q <= (res_d == '0);
      ovf_q  <= ovf_d;
    end
  end

  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected results are queued at drive time and popped on out_valid.
// Zero/Overflow are checked when ALU_STATUS_FLAGS_EN is defined.
module tb_alu;
  localparam int W = 8;

  typedef struct {
    int res;
    bit carry;
    bit zero;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last;

  alu_if #(.WIDTH(W)) bus ();
  alu #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int sel);
    exp_t e;
    int r = 0;
    bit c = 0;
    logic [7:0] av = a[7:0];
    logic [7:0] bv = b[7:0];
    int s;
    case (sel)
      0:  begin r = a + b; c = (r > 255); end
      1:  begin r = a - b; c = (a < b); end
      2:  begin r = a * b; c = (r > 255); end
      3:  if (b == 0) begin r = 255; c = 1; end else r = a / b;
      4:  begin r = a * 2; c = (a >= 128); end
      5:  begin r = a / 2; c = (a % 2 == 1); end
      6:  r = (a * 2) % 256 + a / 128;
      7:  r = a / 2 + (a % 2) * 128;
      8:  r = int'(av & bv);
      9:  r = int'(av | bv);
      10: r = int'(av ^ bv);
      11: r = int'(~(av | bv));
      12: r = int'(~(av & bv));
      13: r = int'(~(av ^ bv));
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    e.res   = r & 255;
    e.carry = c;
    e.zero  = (e.res == 0);
    e.ovf   = 0;
    if (sel == 0) begin
      s = to_signed(a) + to_signed(b);
      e.ovf = (s > 127) || (s < -128);
    end else if (sel == 1) begin
      s = to_signed(a) - to_signed(b);
      e.ovf = (s > 127) || (s < -128);
    end
    return e;
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, "_out"},   bus.ALU_Out,  last.res);
    check({tag, "_carry"}, bus.CarryOut, last.carry);
`ifdef ALU_STATUS_FLAGS_EN
    check({tag, "_zero"},  bus.Zero,     last.zero);
    check({tag, "_ovf"},   bus.Overflow, last.ovf);
`endif
  endtask

  // One cycle: drive at negedge, sample 1ns after the following posedge.
  task automatic step(input string tag, input int a, input int b, input int sel, input bit v);
    @(negedge clk);
    bus.A        = a[7:0];
    bus.B        = b[7:0];
    bus.ALU_Sel  = sel[3:0];
    bus.in_valid = v;
    if (v) sb.push_back(model(a, b, sel));
    @(posedge clk);
    #1;
    check({tag, "_valid"}, bus.out_valid, v);
    if (bus.out_valid) begin
      check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) last = sb.pop_front();
    end
    compare_outputs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"},   bus.ALU_Out,   0);
    check({tag, "_carry"}, bus.CarryOut,  0);
    check({tag, "_valid"}, bus.out_valid, 0);
`ifdef ALU_STATUS_FLAGS_EN
    check({tag, "_zero"},  bus.Zero,      0);
    check({tag, "_ovf"},   bus.Overflow,  0);
`endif
  endtask

  initial begin
    int sweep_tab[16] = '{14, 12, 13, 13, 26, 6, 26, 134, 1, 13, 12, 242, 254, 243, 1, 0};
    rst_n        = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.ALU_Sel  = '0;
    bus.in_valid = 1'b0;
    last         = '{res: 0, carry: 0, zero: 0, ovf: 0};

    // Reset state, held across an edge with in_valid high.
    #2;
    check_reset_state("por");
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check_reset_state("por_hold");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("post_release");

    // Full sweep with A=13, B=1.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep%0d", i), 13, 1, i, 1'b1);
      check($sformatf("sweep%0d_tab", i), bus.ALU_Out, sweep_tab[i]);
      check($sformatf("sweep%0d_cy", i), bus.CarryOut, (i == 5) ? 1 : 0);
    end

    // Carry, borrow, product overflow, divide by zero.
    step("add_carry", 200, 100, 0, 1'b1);
    check("add_carry_spec", {bus.CarryOut, bus.ALU_Out}, {1'b1, 8'd44});
    step("sub_borrow", 5, 10, 1, 1'b1);
    check("sub_borrow_spec", {bus.CarryOut, bus.ALU_Out}, {1'b1, 8'd251});
    step("mul_ovf", 16, 16, 2, 1'b1);
    check("mul_ovf_spec", {bus.CarryOut, bus.ALU_Out}, {1'b1, 8'd0});
    step("div_zero", 7, 0, 3, 1'b1);
    check("div_zero_spec", {bus.CarryOut, bus.ALU_Out}, {1'b1, 8'd255});

    // Throughput and hold: valid pattern 1,1,0,1.
    step("thr0", 50, 20, 0, 1'b1);
    step("thr1", 50, 20, 1, 1'b1);
    step("thr_idle", 99, 3, 2, 1'b0);
    check("thr_idle_hold", bus.ALU_Out, 30);
    step("thr3", 50, 20, 10, 1'b1);

    // Signed overflow and zero flag cases.
    step("flag_add", 127, 1, 0, 1'b1);
    check("flag_add_spec", bus.ALU_Out, 128);
    step("flag_sub", 128, 1, 1, 1'b1);
    step("flag_eq", 3, 4, 15, 1'b1);
    check("flag_eq_spec", bus.ALU_Out, 0);
`ifdef ALU_STATUS_FLAGS_EN
    step("flag_add2", 127, 1, 0, 1'b1);
    check("flag_add_ovf_spec", {bus.Overflow, bus.Zero}, 2'b10);
    step("flag_eq2", 3, 4, 15, 1'b1);
    check("flag_eq_zero_spec", bus.Zero, 1);
`endif

    // Random mixed traffic with occasional idle cycles.
    for (int i = 0; i < 40; i++) begin
      step($sformatf("rnd%0d", i), $urandom_range(255), $urandom_range(255),
           $urandom_range(15), ($urandom_range(3) != 0));
    end

    // Mid-cycle reset discards an in-flight operation.
    @(negedge clk);
    bus.A = 8'd200; bus.B = 8'd100; bus.ALU_Sel = 4'd0; bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(posedge clk); #1;
    check_reset_state("mid_rst_hold");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("mid_rst_release");
    last = '{res: 0, carry: 0, zero: 0, ovf: 0};
    step("after_rst_idle", 1, 1, 0, 1'b0);
    step("after_rst_first", 9, 4, 1, 1'b1);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
